// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frame controller behind the 2-bit UART receiver.
// Assembles SYNC + 4 payload symbols + XOR check into one command byte,
// hands it downstream over valid/ready, and flags check, timeout and
// overrun errors as single-cycle pulses.
module uart_cmd_ctrl #(
   parameter int         CLK_FREQ       = 50000000,
   parameter int         BAUD_RATE      = 9600,
   parameter int         TIMEOUT_CYCLES = 208320,
   parameter logic [1:0] SYNC_SYM       = 2'b10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] rx_data,
   input  logic       rx_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_byte,
   output logic       cmd_valid,
   output logic       busy,
   output logic       err_check,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic [7:0] frame_count,
   output logic [1:0] state_dbg
);

   // Timer only has to reach TIMEOUT_CYCLES-1.
   localparam int          TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

   // Reject parameter sets that cannot produce a sane bit timing or timeout.
   if (TIMEOUT_CYCLES < 2 || BAUD_RATE <= 0 || CLK_FREQ < BAUD_RATE) begin : g_param_err
      $error("uart_cmd_ctrl: invalid parameters");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t        state;
   logic [1:0]    idx;
   logic [1:0]    acc;
   logic [TW-1:0] timer;
   logic          tmr_expired;

   // Expiry only matters when no symbol arrives in the same cycle.
   assign tmr_expired = (timer == TMR_LAST) && !rx_valid;

   // Frame FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 2'd0;
         acc         <= 2'd0;
         timer       <= '0;
         cmd_byte    <= 8'd0;
         cmd_valid   <= 1'b0;
         busy        <= 1'b0;
         err_check   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         frame_count <= 8'd0;
         state_dbg   <= IDLE;
      end else begin
         err_check   <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         case (state)
            IDLE: begin
               // Hunt for SYNC; everything else is line noise.
               if (rx_valid && rx_data == SYNC_SYM) begin
                  state     <= PAYLOAD;
                  state_dbg <= PAYLOAD;
                  busy      <= 1'b1;
                  idx       <= 2'd0;
                  acc       <= 2'd0;
                  timer     <= '0;
               end
            end
            PAYLOAD: begin
               if (rx_valid) begin
                  // LSB-first packing; SYNC value is plain data here.
                  cmd_byte[{idx, 1'b0} +: 2] <= rx_data;
                  acc   <= acc ^ rx_data;
                  idx   <= idx + 2'd1;
                  timer <= '0;
                  if (idx == 2'd3) begin
                     state     <= CHECK;
                     state_dbg <= CHECK;
                  end
               end else if (tmr_expired) begin
                  state       <= IDLE;
                  state_dbg   <= IDLE;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CHECK: begin
               if (rx_valid) begin
                  timer <= '0;
                  if (rx_data == acc) begin
                     state       <= HOLD;
                     state_dbg   <= HOLD;
                     cmd_valid   <= 1'b1;
                     frame_count <= frame_count + 8'd1;
                  end else begin
                     state     <= IDLE;
                     state_dbg <= IDLE;
                     busy      <= 1'b0;
                     err_check <= 1'b1;
                  end
               end else if (tmr_expired) begin
                  state       <= IDLE;
                  state_dbg   <= IDLE;
                  busy        <= 1'b0;
                  err_timeout <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            HOLD: begin
               // No room for another byte: any symbol here is lost.
               if (rx_valid)
                  err_overrun <= 1'b1;
               // cmd_valid is always high in HOLD, so ready alone completes it.
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= IDLE;
                  state_dbg <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               state_dbg <= IDLE;
               busy      <= 1'b0;
               cmd_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
